// File: rtl/rs_ssc_dsd_decoder_pipe.sv
// Streaming RS(N,K) SSC-DSD decoder over GF(2^8): capture, syndrome, classify and correct stages.
// Define RS_DEC_ERR_CNT_EN to add saturating CE/DUE event counters with a synchronous clear.
module rs_ssc_dsd_decoder_pipe #(
    parameter int DATA_SYMS = 36,
    parameter int SYM_W     = 8,
    parameter int CHK_SYMS  = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [(DATA_SYMS+CHK_SYMS)*SYM_W-1:0] in_codeword,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [1:0]                            out_result,
    output logic [DATA_SYMS*SYM_W-1:0]            out_data,
    output logic [7:0]                            out_err_loc
`ifdef RS_DEC_ERR_CNT_EN
    ,
    input  logic                                  cnt_clr,
    output logic [31:0]                           ce_cnt,
    output logic [31:0]                           due_cnt
`endif
);
    localparam int N      = DATA_SYMS + CHK_SYMS;
    localparam int K      = DATA_SYMS;
    localparam int STAGES = 3;
    localparam logic [8:0] N9 = 9'(N);
    localparam logic [1:0] RES_NE  = 2'b00;
    localparam logic [1:0] RES_CE  = 2'b01;
    localparam logic [1:0] RES_DUE = 2'b10;

    typedef logic [255:0][7:0] gf_tbl_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic gf_tbl_t gen_exp();
        gf_tbl_t t;
        logic [7:0] x;
        x = 8'h01;
        for (int e = 0; e < 256; e++) begin
            t[8'(e)] = x;
            x = gf_xtime(x);
        end
        return t;
    endfunction

    function automatic gf_tbl_t gen_log();
        gf_tbl_t t;
        logic [7:0] x;
        t = '0;
        x = 8'h01;
        for (int e = 0; e < 255; e++) begin
            t[x] = 8'(e);
            x = gf_xtime(x);
        end
        return t;
    endfunction

    localparam gf_tbl_t GF_EXP = gen_exp();
    localparam gf_tbl_t GF_LOG = gen_log();

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    logic [STAGES:0]          vld_pipe;
    logic                     en;
    logic [N*SYM_W-1:0]       s1_cw;
    logic [K*SYM_W-1:0]       s2_data, s3_data, fix_data;
    logic [7:0]               syn0_n, syn1_n, syn2_n;
    logic [7:0]               s2_syn0, s2_syn1, s2_syn2;
    logic [7:0]               s3_s0, s3_loc, loc_n, sq, pr;
    logic [1:0]               s3_res, res_n;
    logic [8:0]               ldiff;

    assign en        = !vld_pipe[STAGES] | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    always_comb begin
        syn0_n = 8'h00;
        syn1_n = 8'h00;
        syn2_n = 8'h00;
        for (int i = 0; i < N; i++) begin
            syn0_n = syn0_n ^ s1_cw[i*SYM_W +: SYM_W];
            syn1_n = syn1_n ^ gf_mul(s1_cw[i*SYM_W +: SYM_W], GF_EXP[8'(i % 255)]);
            syn2_n = syn2_n ^ gf_mul(s1_cw[i*SYM_W +: SYM_W], GF_EXP[8'((2*i) % 255)]);
        end
    end

    // Single error e at j gives S = (e, e*a^j, e*a^2j): S1^2 == S0*S2 and j = log S1 - log S0.
    always_comb begin
        sq    = gf_mul(s2_syn1, s2_syn1);
        pr    = gf_mul(s2_syn0, s2_syn2);
        ldiff = {1'b0, GF_LOG[s2_syn1]} - {1'b0, GF_LOG[s2_syn0]};
        if (ldiff[8]) ldiff = ldiff + 9'd255;
        res_n = RES_DUE;
        loc_n = 8'h00;
        if (s2_syn0 == 8'h00 && s2_syn1 == 8'h00 && s2_syn2 == 8'h00) begin
            res_n = RES_NE;
        end else if (s2_syn0 != 8'h00 && s2_syn1 != 8'h00 && sq == pr && ldiff < N9) begin
            res_n = RES_CE;
            loc_n = ldiff[7:0];
        end
    end

    // Check-symbol errors (loc >= K) match no data lane and leave the data untouched.
    always_comb begin
        fix_data = s3_data;
        for (int j = 0; j < K; j++) begin
            if (s3_res == RES_CE && s3_loc == 8'(j))
                fix_data[j*SYM_W +: SYM_W] = s3_data[j*SYM_W +: SYM_W] ^ s3_s0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_cw   <= in_codeword;
            s2_data <= s1_cw[K*SYM_W-1:0];
            s2_syn0 <= syn0_n;
            s2_syn1 <= syn1_n;
            s2_syn2 <= syn2_n;
            s3_data <= s2_data;
            s3_s0   <= s2_syn0;
            s3_res  <= res_n;
            s3_loc  <= loc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_result  <= 2'b00;
            out_data    <= '0;
            out_err_loc <= 8'h00;
        end else if (en && vld_pipe[STAGES-1]) begin
            out_result  <= s3_res;
            out_data    <= fix_data;
            out_err_loc <= s3_loc;
        end
    end

`ifdef RS_DEC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            ce_cnt  <= 32'h0;
            due_cnt <= 32'h0;
        end else if (out_valid && out_ready) begin
            if (out_result == RES_CE && ce_cnt != 32'hFFFF_FFFF)   ce_cnt  <= ce_cnt + 32'h1;
            if (out_result == RES_DUE && due_cnt != 32'hFFFF_FFFF) due_cnt <= due_cnt + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_rs_ssc_dsd_decoder_pipe.sv
// Directed bench for rs_ssc_dsd_decoder_pipe: single words, stalled stream, mid-flight reset.
module tb_rs_ssc_dsd_decoder_pipe;
    localparam int N = 39;
    localparam int K = 36;

    logic           clk = 1'b0;
    logic           rst_n, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [N*8-1:0] in_codeword;
    logic [1:0]     out_result;
    logic [K*8-1:0] out_data;
    logic [7:0]     out_err_loc;
`ifdef RS_DEC_ERR_CNT_EN
    logic [31:0]    ce_cnt, due_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [N*8-1:0] v_cw  [8];
    logic [K*8-1:0] v_dat [8];
    logic [1:0]     v_res [8];
    logic [7:0]     v_loc [8];

    rs_ssc_dsd_decoder_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_data(out_data), .out_err_loc(out_err_loc)
`ifdef RS_DEC_ERR_CNT_EN
        , .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .due_cnt(due_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N*8-1:0] got, input logic [N*8-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*8-1:0] put(input logic [N*8-1:0] cw, input int i, input logic [7:0] v);
        cw[8*i +: 8] = v;
        return cw;
    endfunction

    // g(x) = (x+1)(x+a)(x+a^2) = x^3 + 07x^2 + 0Ex + 08, shifted to start at symbol m
    function automatic logic [N*8-1:0] g_at(input int m);
        return put(put(put(put('0, m, 8'h08), m+1, 8'h0E), m+2, 8'h07), m+3, 8'h01);
    endfunction

    task automatic send_one(input int k);
        in_codeword = v_cw[k];
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk($sformatf("v%0d_early", k), out_valid, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid", k), out_valid, 1'b1);
        chk($sformatf("v%0d_res", k), out_result, v_res[k]);
        chk($sformatf("v%0d_data", k), out_data, v_dat[k]);
        chk($sformatf("v%0d_loc", k), out_err_loc, v_loc[k]);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        logic [N*8-1:0] cw;
        logic [1:0]     hr;
        logic [K*8-1:0] hd;
        logic [7:0]     hl;
        logic           held, fire_in;
        int             ii, oi;

        v_cw[0] = '0;                          v_dat[0] = '0;        v_res[0] = 2'b00; v_loc[0] = 8'd0;
        v_cw[1] = put('0, 37, 8'hAD);          v_dat[1] = '0;        v_res[1] = 2'b01; v_loc[1] = 8'd37;
        cw = g_at(3);                          v_dat[2] = cw[K*8-1:0];
        v_cw[2] = put(cw, 5, 8'h3B);                                 v_res[2] = 2'b01; v_loc[2] = 8'd5;
        v_cw[3] = put(put('0, 38, 8'hA3), 36, 8'hAD); v_dat[3] = '0; v_res[3] = 2'b10; v_loc[3] = 8'd0;
        cw = g_at(0);      v_cw[4] = cw;       v_dat[4] = cw[K*8-1:0]; v_res[4] = 2'b00; v_loc[4] = 8'd0;
        v_cw[5] = put('0, 35, 8'h01);          v_dat[5] = '0;        v_res[5] = 2'b01; v_loc[5] = 8'd35;
        cw = put(put(g_at(0), 10, 8'h11), 20, 8'h22);
        v_cw[6] = cw;                          v_dat[6] = cw[K*8-1:0]; v_res[6] = 2'b10; v_loc[6] = 8'd0;
        cw = g_at(32);                         v_dat[7] = cw[K*8-1:0];
        v_cw[7] = put(cw, 38, 8'h5A);                                v_res[7] = 2'b01; v_loc[7] = 8'd38;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; in_codeword = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_res", out_result, 2'b00);
        chk("rst_data", out_data, '0);
        chk("rst_loc", out_err_loc, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        send_one(0);
        pulse_clr();
        send_one(1);
        send_one(2);
        send_one(3);
`ifdef RS_DEC_ERR_CNT_EN
        chk("ce_cnt_t4", ce_cnt, 32'd2);
        chk("due_cnt_t4", due_cnt, 32'd1);
`endif
        for (int k = 4; k < 8; k++) send_one(k);
`ifdef RS_DEC_ERR_CNT_EN
        chk("ce_cnt_all", ce_cnt, 32'd4);
        chk("due_cnt_all", due_cnt, 32'd2);
`endif

        // Back-to-back stream with out_ready dropped for four cycles once results flow.
        ii = 0; oi = 0; held = 1'b0; fire_in = 1'b0;
        hr = '0; hd = '0; hl = '0;
        for (int cyc = 0; cyc < 60 && oi < 8; cyc++) begin
            @(posedge clk); #1;
            if (fire_in) ii++;
            in_valid    = (ii < 8);
            in_codeword = v_cw[(ii < 8) ? ii : 0];
            out_ready   = !(cyc >= 5 && cyc <= 8);
            #1;
            if (!out_ready && out_valid) begin
                chk("stall_in_ready", in_ready, 1'b0);
                if (held) begin
                    chk("stall_res", out_result, hr);
                    chk("stall_data", out_data, hd);
                    chk("stall_loc", out_err_loc, hl);
                end
                held = 1'b1; hr = out_result; hd = out_data; hl = out_err_loc;
            end else if (out_ready) begin
                chk("run_in_ready", in_ready, 1'b1);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("s%0d_res", oi), out_result, v_res[oi]);
                chk($sformatf("s%0d_data", oi), out_data, v_dat[oi]);
                chk($sformatf("s%0d_loc", oi), out_err_loc, v_loc[oi]);
                oi++;
                held = 1'b0;
            end
            fire_in = in_valid && in_ready;
        end
        chk("stream_count", oi, 8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
`ifdef RS_DEC_ERR_CNT_EN
        chk("ce_cnt_stream", ce_cnt, 32'd8);
        chk("due_cnt_stream", due_cnt, 32'd4);
        pulse_clr();
        chk("ce_cnt_clr", ce_cnt, 32'd0);
        chk("due_cnt_clr", due_cnt, 32'd0);
`endif

        // Two words in flight, then a one-cycle reset must discard both.
        in_valid = 1'b1; in_codeword = v_cw[7];
        @(posedge clk); #1;
        in_codeword = v_cw[6];
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_res", out_result, 2'b00);
        chk("mid_rst_loc", out_err_loc, 8'h00);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_valid%0d", c), out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
